// File: rtl/riio_gpi_pkg.sv
//------------------------------------------------------------------------------
// Module   : riio_gpi_pkg
// Brief    : Shared types and constants for the riio GPI bank.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package riio_gpi_pkg;

  // Per-channel pull mode, as carried on each 2-bit slice of MODE_I
  typedef enum logic [1:0] {
    NONE = 2'b00,
    PD   = 2'b01,
    PU   = 2'b10,
    KEEP = 2'b11
  } gpi_mode_e;

  // Bit positions inside each channel's 2-bit interrupt mask slice
  localparam int c_MASK_RISE = 0;
  localparam int c_MASK_FALL = 1;

endpackage

`default_nettype wire

// File: rtl/riio_gpi_chan.sv
//------------------------------------------------------------------------------
// Module   : riio_gpi_chan
// Brief    : One GPI channel: synchroniser, glitch filter, edge detect,
//            sticky pending flag and pad pull decode.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module riio_gpi_chan
  import riio_gpi_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_W      = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_pad,
  input  logic              i_en,
  input  logic [1:0]        i_mode,
  input  logic [FILT_W-1:0] i_filt,
  input  logic [1:0]        i_mask,
  input  logic              i_clr,
  output logic              o_pu,
  output logic              o_pd,
  output logic              o_lvl,
  output logic              o_rise,
  output logic              o_fall,
  output logic              o_pend
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [FILT_W-1:0]      r_cnt;
  logic                   r_lvl;
  logic                   r_rise;
  logic                   r_fall;
  logic                   r_pend;

  logic                   w_s;
  logic [FILT_W-1:0]      w_f;
  logic                   w_thr_hit;
  logic                   w_set;
  logic                   w_keep_hi;
  gpi_mode_e              w_mode;

  assign w_s       = r_sync[SYNC_STAGES-1];
  // Thresholds 0 and 1 both collapse to a single-sample acceptance
  assign w_f       = (i_filt == '0) ? FILT_W'(1) : i_filt;
  // >= rather than == so a threshold lowered below the running count fires at once
  assign w_thr_hit = (r_cnt >= (w_f - FILT_W'(1)));
  assign w_set     = (r_rise & i_mask[c_MASK_RISE]) | (r_fall & i_mask[c_MASK_FALL]);
  assign w_mode    = gpi_mode_e'(i_mode);
  assign w_keep_hi = r_lvl & i_en;

  // Synchroniser chain for the asynchronous pad data; disabled channels read 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else if (!i_en) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_pad};
    end
  end

  // Debounce filter: accept a new level after F consecutive differing samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_lvl  <= 1'b0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      if (!i_en) begin
        // Disable drops the level silently, without an edge pulse
        r_cnt <= '0;
        r_lvl <= 1'b0;
      end else if (w_s == r_lvl) begin
        r_cnt <= '0;
      end else if (w_thr_hit) begin
        r_lvl  <= w_s;
        r_cnt  <= '0;
        r_rise <= w_s;
        r_fall <= ~w_s;
      end else if (r_cnt != '1) begin
        r_cnt <= r_cnt + FILT_W'(1);
      end
    end
  end

  // Sticky pending flag; a new set outranks a simultaneous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend <= 1'b0;
    end else begin
      r_pend <= w_set | (r_pend & ~i_clr);
    end
  end

  // Pad pull decode; keeper follows the registered level so it cannot glitch
  always_comb begin
    o_pu = 1'b0;
    o_pd = 1'b0;
    case (w_mode)
      NONE: begin
        o_pu = 1'b0;
        o_pd = 1'b0;
      end
      PD: o_pd = i_en;
      PU: o_pu = i_en;
      KEEP: begin
        o_pu = w_keep_hi;
        o_pd = ~w_keep_hi;
      end
      default: begin
        o_pu = 1'b0;
        o_pd = 1'b0;
      end
    endcase
  end

  assign o_lvl  = r_lvl;
  assign o_rise = r_rise;
  assign o_fall = r_fall;
  assign o_pend = r_pend;

endmodule

`default_nettype wire

// File: rtl/riio_gpi_bank.sv
//------------------------------------------------------------------------------
// Module   : riio_gpi_bank
// Brief    : Multi-channel GPI bank serving one pad group; one channel
//            instance per pad plus the combined interrupt request.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module riio_gpi_bank
  import riio_gpi_pkg::*;
#(
  parameter int N_CH        = 8,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_W      = 8
) (
  input  logic                CLK_I,
  input  logic                RSTN_I,
  input  logic [N_CH-1:0]     PAD_DI_I,
  input  logic [N_CH-1:0]     EN_I,
  input  logic [2*N_CH-1:0]   MODE_I,
  input  logic [FILT_W-1:0]   FILT_I,
  input  logic [2*N_CH-1:0]   IRQ_MASK_I,
  input  logic [N_CH-1:0]     IRQ_CLR_I,
  output logic [N_CH-1:0]     IE_O,
  output logic [N_CH-1:0]     PU_O,
  output logic [N_CH-1:0]     PD_O,
  output logic [N_CH-1:0]     LVL_O,
  output logic [N_CH-1:0]     RISE_O,
  output logic [N_CH-1:0]     FALL_O,
  output logic [N_CH-1:0]     PEND_O,
  output logic                IRQ_O
);

  // Pad receivers are enabled exactly when the channel is enabled
  assign IE_O  = EN_I;
  assign IRQ_O = |PEND_O;

  generate
    for (genvar i = 0; i < N_CH; i++) begin : g_chan
      riio_gpi_chan #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILT_W      (FILT_W)
      ) u_chan (
        .clk    (CLK_I),
        .rst_n  (RSTN_I),
        .i_pad  (PAD_DI_I[i]),
        .i_en   (EN_I[i]),
        .i_mode (MODE_I[2*i +: 2]),
        .i_filt (FILT_I),
        .i_mask (IRQ_MASK_I[2*i +: 2]),
        .i_clr  (IRQ_CLR_I[i]),
        .o_pu   (PU_O[i]),
        .o_pd   (PD_O[i]),
        .o_lvl  (LVL_O[i]),
        .o_rise (RISE_O[i]),
        .o_fall (FALL_O[i]),
        .o_pend (PEND_O[i])
      );
    end
  endgenerate

endmodule

`default_nettype wire

// File: doc/riio_gpi_bank.md
# riio_gpi_bank

Parametrised multi-channel general-purpose-input bank that sits on the core (VDD) side of a row of GPI pad cells. Per channel it drives the pad controls (input enable, pull-up, pull-down, keeper), synchronises the raw pad data, debounces it with a programmable glitch filter, detects edges, and maintains maskable sticky interrupt-pending flags. One instance serves a whole pad group and replaces per-pad glue logic.

## Interface
- N_CH, 8, number of channels (1..32)
- SYNC_STAGES, 2, synchroniser depth (>=2)
- FILT_W, 8, debounce counter / threshold width
- CLK_I  in  1  core clock
- RSTN_I  in  1  reset; asynchronous, active-low
- PAD_DI_I  in  N_CH  raw pad receiver data (DI_O[0] of each pad), asynchronous
- EN_I  in  N_CH  channel enable
- MODE_I  in  2*N_CH  pull mode per channel, [2i+1:2i]: 00 none, 01 pull-down, 10 pull-up, 11 keeper
- FILT_I  in  FILT_W  debounce threshold in cycles, shared; 0 and 1 both mean no filtering
- IRQ_MASK_I  in  2*N_CH  [2i] rise enable, [2i+1] fall enable
- IRQ_CLR_I  in  N_CH  write-1-to-clear pending, one-cycle pulse
- IE_O  out  N_CH  pad input enable (= EN_I, combinational)
- PU_O / PD_O  out  N_CH each  pad pull-up / pull-down enable
- LVL_O  out  N_CH  filtered level
- RISE_O / FALL_O  out  N_CH each  one-cycle edge pulses
- PEND_O  out  N_CH  sticky pending flags
- IRQ_O  out  1  OR of PEND_O

## Operation
- Reset: sync chains, counters, LVL_O, RISE_O, FALL_O and PEND_O are 0. IRQ_O is 0. PU_O/PD_O follow the mode decode below, with LVL=0.
- Sync: SYNC_STAGES flops per channel. Input masked to 0 when EN_I[i]=0. Sync output is s.
- Filter, per channel with counter cnt (FILT_W bits) and F = max(FILT_I,1):
  - s==LVL: cnt<=0.
  - s!=LVL and cnt>=F-1: LVL<=s, cnt<=0, and pulse RISE (s=1) or FALL (s=0).
  - Otherwise: cnt<=cnt+1, saturating at all-ones.
  - FILT_I changes apply immediately; the >= compare guarantees an update on the next edge if cnt already exceeds the new threshold.
- Disable: EN_I[i]=0 synchronously clears sync, cnt and LVL to 0 with no FALL pulse. PEND is retained.
- Pull decode:
  - none: PU=0, PD=0.
  - pd: PU=0, PD=EN.
  - pu: PU=EN, PD=0.
  - keeper: PU=LVL&EN, PD=~(LVL&EN).
  - Keeper uses the registered filtered level and is glitch-free.
- Pending: set <= (RISE&mask_rise)|(FALL&mask_fall), registered one cycle after the pulse.
  - Set and IRQ_CLR_I in the same cycle: set wins.
  - Masking after set does not clear.

## Timing
- Pad change to LVL_O/edge pulse: SYNC_STAGES + F rising edges, with the pad held stable throughout.
- A pad pulse shorter than F cycles, as seen at s, produces no LVL change and no pulse.
- Edge pulse to PEND_O: 1 cycle. PEND_O to IRQ_O: combinational.
- LVL to PU_O/PD_O in keeper mode: combinational from the LVL flop.
- Async reset assertion mid-filter clears everything immediately. Deassertion must be synchronised externally.

## Structure
- Package riio_gpi_pkg holds:
  - enum gpi_mode_e (NONE, PD, PU, KEEP)
  - constants for the mask bit positions
- Sub-module riio_gpi_chan contains one channel: sync, filter, edge, pending and pull decode. The top generates N_CH instances and ORs IRQ_O.

## Test plan
- Reset, then EN=1, FILT_I=0, pad 0->1: LVL_O rises and RISE_O pulses at edge 3 (SYNC_STAGES=2), PEND_O=1 at edge 4 with mask rise=1.
- FILT_I=5, pad high for 4 cycles then low: no LVL change, no pulses. Pad high for 5 cycles: LVL_O=1 at edge 2+5.
- Keeper mode, pad toggled 1->0 with FILT_I=3: PU_O 1->0 and PD_O 0->1 exactly when LVL_O falls. EN=0 gives PU_O=0, PD_O=1.
- PEND_O=1, then IRQ_CLR_I pulsed in the same cycle as a new masked FALL: PEND_O stays 1. Next IRQ_CLR_I alone gives 0, and IRQ_O drops.
- EN_I deasserted while LVL_O=1: LVL_O=0 at the next edge, no FALL_O, PEND_O unchanged.
- FILT_I=200 with cnt at 50, then FILT_I written to 10: LVL_O updates at the next edge. RSTN_I asserted mid-count: all outputs 0 immediately.
